// File: rtl/fpu_pkg.sv
// Shared FP32 constants and packed result/flag types for the add/sub datapath.
package fpu_pkg;

   localparam int EXP_BIAS = 127;
   localparam int EXP_MAX  = 255;
   localparam int MANT_W   = 23;

   typedef struct packed {
      logic              sign;
      logic [7:0]        exp;
      logic [MANT_W-1:0] frac;
   } fp32_t;

   typedef struct packed {
      logic overflow;
      logic underflow;
      logic inexact;
      logic zero;
   } fp_flags_t;

endpackage

// File: rtl/lzc_32.sv
// Leading-zero counter for a 32-bit word; v flags an all-zero input.
module lzc_32 (
   input  logic [31:0] a,
   output logic [4:0]  c,
   output logic        v
);

   logic found;

   always_comb begin
      c     = '0;
      found = 1'b0;
      for (int i = 31; i >= 0; i--) begin
         if (!found && a[i]) begin
            c     = 5'(31 - i);
            found = 1'b1;
         end
      end
      v = !found;
   end

endmodule

// File: rtl/fp_norm_round_32.sv
// Three-stage normalize / round-to-nearest-even / pack stage for FP32 add/sub.
// S1 counts leading zeros, S2 shifts with denormal limiting, S3 rounds and packs.
module fp_norm_round_32
   import fpu_pkg::*;
#(
   parameter bit FLUSH_DENORM = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic        sign_i,
   input  logic [8:0]  exp_i,
   input  logic [31:0] mant_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] result_o,
   output logic        overflow_o,
   output logic        underflow_o,
   output logic        inexact_o,
   output logic        zero_o
);

   // Handshake: a beat transfers on a clock edge where valid && ready; each
   // stage loads when it is empty or its current beat leaves in that edge.
   logic s1_valid, s2_valid, s3_valid;
   logic s1_free, s2_free, s3_free;

   assign s3_free    = !s3_valid || out_ready_i;
   assign s2_free    = !s2_valid || s3_free;
   assign s1_free    = !s1_valid || s2_free;
   assign in_ready_o = s1_free;

   // ---------------- S1: count ----------------
   logic [4:0]  lz_c;
   logic        zero_c;
   logic        s1_sign, s1_zero;
   logic [8:0]  s1_exp;
   logic [31:0] s1_mant;
   logic [4:0]  s1_lz;

   lzc_32 u_lzc (
      .a(mant_i),
      .c(lz_c),
      .v(zero_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (s1_free) begin
         s1_valid <= in_valid_i;
         s1_sign  <= sign_i;
         s1_exp   <= exp_i;
         s1_mant  <= mant_i;
         s1_lz    <= lz_c;
         s1_zero  <= zero_c;
      end
   end

   // ---------------- S2: shift ----------------
   logic signed [9:0] exp_m1, e_c;
   logic              tiny_c;
   logic [4:0]        sh_c;
   logic [31:0]       m_c;

   always_comb begin
      exp_m1 = $signed({1'b0, s1_exp}) - 10'sd1;
      // Shift is capped so the exponent never drops below 1; the cap lands a tiny value as a denormal.
      tiny_c = !s1_zero && ($signed({5'b0, s1_lz}) > exp_m1);
      sh_c   = tiny_c ? exp_m1[4:0] : s1_lz;
      m_c    = s1_mant << sh_c;
      e_c    = tiny_c ? 10'sd0 : $signed({1'b0, s1_exp}) - $signed({5'b0, sh_c});
      if (s1_zero) begin
         m_c = '0;
         e_c = '0;
      end
   end

   logic              s2_sign, s2_tiny;
   logic signed [9:0] s2_e;
   logic [31:0]       s2_m;

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
      end else if (s2_free) begin
         s2_valid <= s1_valid;
         s2_sign  <= s1_sign;
         s2_e     <= e_c;
         s2_m     <= m_c;
         s2_tiny  <= tiny_c;
      end
   end

   // ---------------- S3: round and pack ----------------
   logic      guard, sticky, inc, ovf_c;
   logic [30:0] base_c, packed_c;
   fp32_t     res_c;
   fp_flags_t flg_c;

   always_comb begin
      res_c  = '0;
      flg_c  = '0;
      guard  = s2_m[7];
      sticky = |s2_m[6:0];
      inc    = guard & (sticky | s2_m[8]);
      // Hidden bit clear means denormal or zero: exponent field is 0 and the add can carry into exp 1.
      base_c   = {(s2_m[31] ? s2_e[7:0] : 8'd0), s2_m[30:8]};
      packed_c = base_c + {30'd0, inc};
      ovf_c    = s2_m[31] && ((s2_e >= $signed(10'(EXP_MAX))) ||
                              (packed_c[30:23] == 8'(EXP_MAX)));

      res_c.sign          = s2_sign;
      {res_c.exp, res_c.frac} = packed_c;
      flg_c.overflow      = ovf_c;
      flg_c.inexact       = guard | sticky | ovf_c;
      flg_c.underflow     = s2_tiny & flg_c.inexact;
      if (ovf_c) begin
         res_c.exp  = 8'(EXP_MAX);
         res_c.frac = '0;
      end
      if (FLUSH_DENORM && s2_tiny) begin
         res_c.exp       = '0;
         res_c.frac      = '0;
         flg_c.underflow = 1'b1;
         flg_c.inexact   = 1'b1;
      end
      flg_c.zero = (res_c.exp == 8'd0) && (res_c.frac == '0);
   end

   fp32_t     s3_res;
   fp_flags_t s3_flg;

   always_ff @(posedge clk) begin
      if (rst) begin
         s3_valid <= 1'b0;
      end else if (s3_free) begin
         s3_valid <= s2_valid;
         s3_res   <= res_c;
         s3_flg   <= flg_c;
      end
   end

   assign out_valid_o = s3_valid;
   assign result_o    = s3_valid ? s3_res : 32'd0;
   assign overflow_o  = s3_valid & s3_flg.overflow;
   assign underflow_o = s3_valid & s3_flg.underflow;
   assign inexact_o   = s3_valid & s3_flg.inexact;
   assign zero_o      = s3_valid & s3_flg.zero;

endmodule

// File: tb/tb_fp_norm_round_32.sv
// Scoreboard bench for fp_norm_round_32: default and flush-to-zero instances
// driven in lockstep, checked against an arithmetic reference model.
module tb_fp_norm_round_32;
   import fpu_pkg::*;

   typedef struct packed {
      logic        sign;
      logic [8:0]  exp;
      logic [31:0] mant;
   } beat_t;

   typedef struct packed {
      beat_t       b;
      logic [35:0] e;
      logic [35:0] ef;
   } pend_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid_i = 1'b0;
   logic        sign_i = 1'b0;
   logic [8:0]  exp_i = 9'd1;
   logic [31:0] mant_i = '0;
   logic        out_ready_i = 1'b1;
   logic        in_ready_o, out_valid_o, overflow_o, underflow_o, inexact_o, zero_o;
   logic [31:0] result_o;
   logic        in_ready_f, out_valid_f, overflow_f, underflow_f, inexact_f, zero_f;
   logic [31:0] result_f;

   always #5 clk = ~clk;

   fp_norm_round_32 dut (
      .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .sign_i(sign_i), .exp_i(exp_i), .mant_i(mant_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
      .overflow_o(overflow_o), .underflow_o(underflow_o), .inexact_o(inexact_o), .zero_o(zero_o)
   );

   fp_norm_round_32 #(.FLUSH_DENORM(1'b1)) dut_f (
      .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_f),
      .sign_i(sign_i), .exp_i(exp_i), .mant_i(mant_i),
      .out_valid_o(out_valid_f), .out_ready_i(out_ready_i), .result_o(result_f),
      .overflow_o(overflow_f), .underflow_o(underflow_f), .inexact_o(inexact_f), .zero_o(zero_f)
   );

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          acc_cnt = 0;
   int          out_cnt = 0;
   int          last_pop_cyc = 0;
   pend_t       pend_q[$];
   logic [35:0] exp_q[$];
   logic [35:0] exp_f_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [35:0] act, input logic [35:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference: exact value mant * 2^(exp-bias-31), requantized to the FP32 grid and rounded half-even.
   function automatic logic [35:0] model(input beat_t b, input bit flush);
      int     p, be, s;
      longint q, rem, half, code;
      bit     tiny, inx, ovf, unf;
      if (b.mant == 32'd0) return {b.sign, 31'd0, 4'b0001};
      p = 0;
      for (int i = 0; i < 32; i++) if (b.mant[i]) p = i;
      be   = (p + int'(b.exp) - EXP_BIAS - 31) + EXP_BIAS;
      tiny = (be < 1);
      s    = tiny ? (int'(b.exp) - EXP_BIAS - 31) - (1 - EXP_BIAS - MANT_W) : MANT_W - p;
      if (s >= 0) begin
         q = longint'(b.mant) << s;
         rem = 0;
         half = 1;
      end else begin
         q    = longint'(b.mant) >> (-s);
         rem  = longint'(b.mant) & ((64'sd1 << (-s)) - 1);
         half = 64'sd1 << (-s - 1);
      end
      if (rem > half || (rem == half && q[0])) q++;
      inx  = (rem != 0);
      code = tiny ? q : longint'(be) * (64'sd1 << MANT_W) + q - (64'sd1 << MANT_W);
      ovf  = (code >= longint'(EXP_MAX) * (64'sd1 << MANT_W));
      if (ovf) begin
         code = longint'(EXP_MAX) << MANT_W;
         inx  = 1'b1;
      end
      unf = tiny && inx;
      if (flush && tiny) begin
         code = 0;
         unf  = 1'b1;
         inx  = 1'b1;
      end
      return {b.sign, code[30:0], ovf, unf, inx, code == 0};
   endfunction

   function automatic pend_t rand_pend();
      pend_t p;
      int    r;
      p.b.sign = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r < 3)      p.b.exp = 9'($urandom_range(1, 40));
      else if (r < 8) p.b.exp = 9'($urandom_range(41, 260));
      else            p.b.exp = 9'($urandom_range(261, 511));
      p.b.mant = $urandom() >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) p.b.mant = (p.b.mant & 32'hFFFF_FF00) | 32'h0000_0080;
      if ($urandom_range(0, 19) == 0) p.b.mant = 32'd0;
      p.e  = model(p.b, 1'b0);
      p.ef = model(p.b, 1'b1);
      return p;
   endfunction

   // Driver: present the head of pend_q for one cycle; push its expectation on acceptance.
   task automatic step();
      pend_t p;
      bit    acc;
      p = '0;
      if (pend_q.size() > 0) begin
         p          = pend_q[0];
         in_valid_i = 1'b1;
         sign_i     = p.b.sign;
         exp_i      = p.b.exp;
         mant_i     = p.b.mant;
      end else begin
         in_valid_i = 1'b0;
      end
      @(negedge clk);
      acc = in_valid_i && in_ready_o;
      @(posedge clk);
      if (acc) begin
         exp_q.push_back(p.e);
         exp_f_q.push_back(p.ef);
         void'(pend_q.pop_front());
         acc_cnt++;
      end
      #1;
   endtask

   task automatic drain();
      int g;
      g = 0;
      out_ready_i = 1'b1;
      while ((pend_q.size() > 0 || exp_q.size() > 0) && g < 200) begin
         step();
         g++;
      end
      check("drain_left", 36'(pend_q.size() + exp_q.size()), 36'd0);
   endtask

   // Monitor: pops and compares whenever a result transfers; checks hold while stalled.
   logic [35:0] cur, cur_f, prev_cur, e_v, ef_v;
   bit          prev_stall = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         cur   = {result_o, overflow_o, underflow_o, inexact_o, zero_o};
         cur_f = {result_f, overflow_f, underflow_f, inexact_f, zero_f};
         if (out_valid_o && exp_q.size() == 0) check("spurious_out", 36'(out_valid_o), 36'd0);
         if (out_valid_o && out_ready_i && exp_q.size() > 0) begin
            e_v  = exp_q.pop_front();
            ef_v = exp_f_q.pop_front();
            check("result", cur, e_v);
            check("result_flush", cur_f, ef_v);
            check("valid_flush", 36'(out_valid_f), 36'd1);
            out_cnt++;
            last_pop_cyc = cyc;
         end
         if (out_valid_o && !out_ready_i && prev_stall) check("hold", cur, prev_cur);
         prev_stall = out_valid_o && !out_ready_i;
         prev_cur   = cur;
      end
   end

   task automatic add_dir(input logic s, input logic [8:0] e, input logic [31:0] m,
                          input logic [35:0] ex, input logic [35:0] exf);
      pend_t p;
      p.b.sign = s;
      p.b.exp  = e;
      p.b.mant = m;
      p.e      = ex;
      p.ef     = exf;
      pend_q.push_back(p);
   endtask

   initial begin
      int t0, a0, n0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_state", {result_o, out_valid_o, in_ready_o, overflow_o, underflow_o},
            {32'd0, 1'b0, 1'b1, 2'b00});
      check("reset_flags", {32'd0, inexact_o, zero_o, out_valid_f, result_f == 32'd0}, 36'h1);
      @(posedge clk);
      #1;

      // Directed vectors, one at a time with latency measured from the presenting cycle.
      for (int i = 0; i < 11; i++) begin
         case (i)
            0: add_dir(0, 9'd100, 32'h0000_8000, {32'h2A00_0000, 4'b0000}, {32'h2A00_0000, 4'b0000});
            1: add_dir(0, 9'd10,  32'hFFFF_FF80, {32'h0580_0000, 4'b0010}, {32'h0580_0000, 4'b0010});
            2: add_dir(0, 9'd10,  32'h8000_0080, {32'h0500_0000, 4'b0010}, {32'h0500_0000, 4'b0010});
            3: add_dir(0, 9'd5,   32'h0000_0100, {32'h0000_0010, 4'b0000}, {32'h0000_0000, 4'b0111});
            4: add_dir(0, 9'd5,   32'h0000_0101, {32'h0000_0010, 4'b0110}, {32'h0000_0000, 4'b0111});
            5: add_dir(0, 9'd255, 32'h8000_0000, {32'h7F80_0000, 4'b1010}, {32'h7F80_0000, 4'b1010});
            6: add_dir(1, 9'd50,  32'h0000_0000, {32'h8000_0000, 4'b0001}, {32'h8000_0000, 4'b0001});
            7: add_dir(0, 9'd1,   32'h8000_0000, {32'h0080_0000, 4'b0000}, {32'h0080_0000, 4'b0000});
            8: add_dir(0, 9'd254, 32'hFFFF_FF80, {32'h7F80_0000, 4'b1010}, {32'h7F80_0000, 4'b1010});
            9: add_dir(1, 9'd1,   32'h7FFF_FF80, {32'h8080_0000, 4'b0110}, {32'h8000_0000, 4'b0111});
            default: add_dir(0, 9'd511, 32'h0000_0001, {32'h7F80_0000, 4'b1010}, {32'h7F80_0000, 4'b1010});
         endcase
         t0 = cyc;
         drain();
         check($sformatf("latency_%0d", i), 36'(last_pop_cyc - t0), 36'd3);
      end

      // Backpressure: five beats offered over six stalled cycles.
      out_ready_i = 1'b0;
      for (int k = 0; k < 5; k++) pend_q.push_back(rand_pend());
      a0 = acc_cnt;
      repeat (6) step();
      check("bp_accepted", 36'(acc_cnt - a0), 36'd3);
      in_valid_i = 1'b0;
      @(negedge clk);
      check("bp_in_ready", 36'(in_ready_o), 36'd0);
      @(posedge clk);
      #1;
      out_ready_i = 1'b1;
      n0 = out_cnt;
      repeat (5) step();
      check("bp_no_gap", 36'(out_cnt - n0), 36'd5);
      drain();

      // Reset with two beats in flight.
      pend_q.push_back(rand_pend());
      pend_q.push_back(rand_pend());
      step();
      step();
      in_valid_i = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      exp_f_q.delete();
      @(negedge clk);
      check("rst_flush", {result_o, out_valid_o, in_ready_o, 2'b00}, {32'd0, 1'b0, 1'b1, 2'b00});
      @(posedge clk);
      #1;
      repeat (6) step();

      // Random traffic with random backpressure and idle cycles.
      for (int n = 0; n < 400; n++) begin
         out_ready_i = ($urandom_range(0, 3) != 0);
         if (pend_q.size() == 0 && $urandom_range(0, 4) != 0) pend_q.push_back(rand_pend());
         step();
      end
      drain();
      repeat (4) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
